// File: rtl/dla_kpe_ctrl_if.sv
// rtl/dla_kpe_ctrl_if.sv - command and operand handshakes between scheduler and KPE lane controller
interface dla_kpe_ctrl_if #(
   parameter int LEN_W = 8
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [LEN_W-1:0] cmd_len;
   logic             cmd_bypass;
   logic             cmd_abort;
   logic             op_valid;
   logic             op_ready;

   modport master (
      output cmd_valid, cmd_len, cmd_bypass, cmd_abort, op_valid,
      input  cmd_ready, op_ready
   );

   modport slave (
      input  cmd_valid, cmd_len, cmd_bypass, cmd_abort, op_valid,
      output cmd_ready, op_ready
   );
endinterface

// File: rtl/dla_kpe_ctrl.sv
// rtl/dla_kpe_ctrl.sv - KPE lane sequencer: turns window commands into KPE stage enables
module dla_kpe_ctrl #(
   parameter int LEN_W    = 8,
   parameter int PIPE_LAT = 4
) (
   input  logic          clk,
   input  logic          rst,
   dla_kpe_ctrl_if.slave bus,
   output logic          ctrl_kpe_src0_enable,
   output logic          ctrl_kpe_src1_enable,
   output logic          ctrl_kpe_mul_enable,
   output logic          ctrl_kpe_acc_enable,
   output logic          ctrl_kpe_acc_rst,
   output logic          ctrl_kpe_bypass,
   output logic          kpe_enable,
   output logic          sum_valid,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

   state_t              state_q, state_d;
   logic [LEN_W-1:0]    len_q, cnt_q;
   logic                byp_q;
   logic [PIPE_LAT-2:0] v_q, f_q;
   logic [PIPE_LAT-1:0] l_q;
   logic                accept, fire, is_first, is_last, drain_done;
   logic                cmd_ready_c, op_ready_c;

   assign is_first   = (cnt_q == '0);
   assign is_last    = (cnt_q == (len_q - LEN_ONE));
   // bypass results leave straight from the source register, so nothing remains to drain
   assign drain_done = byp_q | ~|v_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.cmd_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept) state_d = (bus.cmd_len == '0) ? DONE : RUN;
            RUN:     if (fire && is_last) state_d = DRAIN;
            DRAIN:   if (drain_done) state_d = IDLE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      cmd_ready_c          = (state_q == IDLE) && !bus.cmd_abort;
      op_ready_c           = (state_q == RUN) && !bus.cmd_abort;
      accept               = bus.cmd_valid && cmd_ready_c;
      fire                 = bus.op_valid && op_ready_c;
      busy                 = (state_q != IDLE);
      kpe_enable           = busy;
      ctrl_kpe_src0_enable = fire;
      ctrl_kpe_src1_enable = fire && !byp_q;
      ctrl_kpe_mul_enable  = v_q[0] && !byp_q;
      ctrl_kpe_acc_enable  = v_q[PIPE_LAT-2] && !byp_q;
      ctrl_kpe_acc_rst     = v_q[PIPE_LAT-2] && f_q[PIPE_LAT-2] && !byp_q;
      ctrl_kpe_bypass      = byp_q;
      sum_valid            = byp_q ? v_q[0] : l_q[PIPE_LAT-1];
   end

   assign bus.cmd_ready = cmd_ready_c;
   assign bus.op_ready  = op_ready_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_q <= '0;
         cnt_q <= '0;
         byp_q <= 1'b0;
         v_q   <= '0;
         f_q   <= '0;
         l_q   <= '0;
      end else if (bus.cmd_abort) begin
         cnt_q <= '0;
         byp_q <= 1'b0;
         v_q   <= '0;
         f_q   <= '0;
         l_q   <= '0;
      end else begin
         // in bypass only the first valid stage is live so no stale bits reach acc_enable
         v_q <= {v_q[PIPE_LAT-3:0] & {(PIPE_LAT-2){~byp_q}}, fire};
         f_q <= {f_q[PIPE_LAT-3:0], fire && is_first && !byp_q};
         l_q <= {l_q[PIPE_LAT-2] & v_q[PIPE_LAT-2], l_q[PIPE_LAT-3:0], fire && is_last && !byp_q};
         if (accept) begin
            len_q <= bus.cmd_len;
            byp_q <= bus.cmd_bypass;
            cnt_q <= '0;
         end else if (fire) begin
            cnt_q <= is_last ? '0 : cnt_q + LEN_ONE;
         end
         if (state_q != IDLE && state_d == IDLE) byp_q <= 1'b0;
      end
   end
endmodule

// File: tb/tb_dla_kpe_ctrl.sv
// tb/tb_dla_kpe_ctrl.sv - randomized self-checking bench for dla_kpe_ctrl with a scheduled-event model
module tb_dla_kpe_ctrl;
   localparam int LEN_W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dla_kpe_ctrl_if #(.LEN_W(LEN_W)) bus ();
   logic src0_en, src1_en, mul_en, acc_en, acc_rst, byp_out, kpe_en, sum_valid, busy;

   dla_kpe_ctrl #(.LEN_W(LEN_W), .PIPE_LAT(4)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .bus                 (bus),
      .ctrl_kpe_src0_enable(src0_en),
      .ctrl_kpe_src1_enable(src1_en),
      .ctrl_kpe_mul_enable (mul_en),
      .ctrl_kpe_acc_enable (acc_en),
      .ctrl_kpe_acc_rst    (acc_rst),
      .ctrl_kpe_bypass     (byp_out),
      .kpe_enable          (kpe_en),
      .sum_valid           (sum_valid),
      .busy                (busy)
   );

   // small KPE datapath driven by the controller enables
   logic [7:0]  ifmap = 8'd0, weight = 8'd0;
   logic [7:0]  k_src_f, k_src_w;
   logic [15:0] k_mul, k_rnd;
   logic [31:0] k_acc, kpe_sum;
   always @(posedge clk) begin
      if (src0_en) k_src_f <= ifmap;
      if (src1_en) k_src_w <= weight;
      if (mul_en)  k_mul   <= 16'(k_src_f) * 16'(k_src_w);
      k_rnd <= k_mul;
      if (acc_en)  k_acc   <= (acc_rst ? 32'd0 : k_acc) + 32'(k_rnd);
   end
   assign kpe_sum = byp_out ? {24'd0, k_src_f} : k_acc;

   int nvec = 0, nerr = 0;
   int cyc = 0;

   task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   // model: window bookkeeping plus a ring of scheduled per-cycle enable events
   bit  m_busy = 0, m_byp = 0;
   int  m_rem = 0, m_idx = 0, m_len = 0, m_end = -1, m_dot = 0;
   bit  r_mul [16], r_acc [16], r_rst [16], r_sum [16];
   int  exp_q [$];
   int  fires = 0, accepts = 0, first_fire_cyc = 0, last_fire_cyc = 0, accept_cyc = 0;

   task automatic clear_model();
      m_busy = 0; m_byp = 0; m_rem = 0; m_dot = 0;
      for (int i = 0; i < 16; i++) begin
         r_mul[i] = 0; r_acc[i] = 0; r_rst[i] = 0; r_sum[i] = 0;
      end
      exp_q.delete();
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         clear_model();
      end else begin
         r_mul[cyc % 16] = 0; r_acc[cyc % 16] = 0; r_rst[cyc % 16] = 0; r_sum[cyc % 16] = 0;
         if (bus.cmd_abort) begin
            clear_model();
         end else if (!m_busy) begin
            if (bus.cmd_valid) begin
               m_busy = 1; m_byp = bus.cmd_bypass; m_len = int'(bus.cmd_len);
               m_rem = m_len; m_idx = 0; m_dot = 0;
               accepts++; accept_cyc = cyc;
               m_end = (m_len == 0) ? cyc + 1 : -1;
            end
         end else begin
            if (bus.op_valid && m_rem > 0) begin
               fires++;
               if (m_idx == 0) first_fire_cyc = cyc;
               last_fire_cyc = cyc;
               if (!m_byp) begin
                  r_mul[(cyc + 1) % 16] = 1;
                  r_acc[(cyc + 3) % 16] = 1;
                  r_rst[(cyc + 3) % 16] = (m_idx == 0);
                  m_dot += int'(ifmap) * int'(weight);
                  if (m_rem == 1) begin
                     r_sum[(cyc + 4) % 16] = 1;
                     exp_q.push_back(m_dot);
                  end
               end else begin
                  r_sum[(cyc + 1) % 16] = 1;
                  exp_q.push_back(int'(ifmap));
               end
               m_idx++; m_rem--;
               if (m_rem == 0) m_end = cyc + (m_byp ? 1 : 4);
            end
            if (cyc == m_end) begin
               m_busy = 0; m_byp = 0;
            end
         end
         cyc++;
      end
   end

   int log_val [$], log_cyc [$];
   int rst_cyc = 0, rst_cnt = 0, busy_cnt = 0;

   always @(negedge clk) begin
      int s; bit fe; bit opr; int ev;
      s   = cyc % 16;
      opr = m_busy && m_rem > 0 && !bus.cmd_abort;
      fe  = bus.op_valid && opr;
      chk("cmd_ready",  bus.cmd_ready, !m_busy && !bus.cmd_abort);
      chk("op_ready",   bus.op_ready, opr);
      chk("busy",       busy, m_busy);
      chk("kpe_enable", kpe_en, m_busy);
      chk("src0_en",    src0_en, fe);
      chk("src1_en",    src1_en, fe && !m_byp);
      chk("mul_en",     mul_en, r_mul[s]);
      chk("acc_en",     acc_en, r_acc[s]);
      chk("acc_rst",    acc_rst, r_rst[s]);
      chk("bypass",     byp_out, m_busy && m_byp);
      chk("sum_valid",  sum_valid, r_sum[s]);
      if (sum_valid === 1'b1 && r_sum[s]) begin
         if (exp_q.size() == 0) chk("sum_queue", 0, 1);
         else begin
            ev = exp_q.pop_front();
            chk("kpe_sum", kpe_sum, ev);
         end
      end
      if (sum_valid === 1'b1) begin
         log_val.push_back(int'(kpe_sum));
         log_cyc.push_back(cyc);
      end
      if (acc_rst === 1'b1) begin rst_cyc = cyc; rst_cnt++; end
      if (busy === 1'b1) busy_cnt++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send_cmd(int len, bit b);
      int n;
      n = accepts;
      bus.cmd_valid = 1; bus.cmd_len = LEN_W'(len); bus.cmd_bypass = b;
      for (int i = 0; i < 400 && accepts == n; i++) tick();
      bus.cmd_valid = 0; bus.cmd_len = LEN_W'($urandom); bus.cmd_bypass = 1'($urandom);
      if (accepts == n) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic send_op(int a, int w, int bub);
      int n;
      bus.op_valid = 0;
      for (int i = 0; i < bub; i++) begin
         ifmap = 8'($urandom); weight = 8'($urandom); tick();
      end
      n = fires;
      bus.op_valid = 1; ifmap = 8'(a); weight = 8'(w);
      for (int i = 0; i < 400 && fires == n; i++) tick();
      bus.op_valid = 0;
      if (fires == n) chk("op_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 300 && m_busy; i++) tick();
      if (m_busy) chk("idle_timeout", 0, 1);
      tick();
   endtask

   task automatic pulse_abort();
      bus.cmd_abort = 1; tick(); bus.cmd_abort = 0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int base, rbase, bbase, ln, ab;
      bit bp;
      bus.cmd_valid = 0; bus.cmd_len = '0; bus.cmd_bypass = 0; bus.cmd_abort = 0; bus.op_valid = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", bus.cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_sum_valid", sum_valid, 0);
      @(posedge clk); #1 rst = 0;
      tick();

      // T1: N=4 contiguous, 1+4+9+16
      base = log_val.size(); rbase = rst_cnt;
      send_cmd(4, 0);
      send_op(1, 1, 0); send_op(2, 2, 0); send_op(3, 3, 0); send_op(4, 4, 0);
      wait_idle();
      chk("t1_nsum", log_val.size() - base, 1);
      chk("t1_sum", log_val[base], 30);
      chk("t1_sum_cyc", log_cyc[base] - first_fire_cyc, 7);
      chk("t1_rst_cyc", rst_cyc - first_fire_cyc, 3);
      chk("t1_rst_cnt", rst_cnt - rbase, 1);

      // T2: bubbles between ops 1 and 2, 6+20+7
      base = log_val.size();
      send_cmd(3, 0);
      send_op(2, 3, 0); send_op(4, 5, 2); send_op(1, 7, 0);
      wait_idle();
      chk("t2_sum", log_val[base], 33);
      chk("t2_lat", log_cyc[base] - last_fire_cyc, 4);

      // T3: bypass passes ifmap through
      base = log_val.size();
      send_cmd(3, 1);
      send_op(5, 99, 0); send_op(6, 98, 0); send_op(7, 97, 0);
      wait_idle();
      chk("t3_nsum", log_val.size() - base, 3);
      chk("t3_sum0", log_val[base], 5);
      chk("t3_sum1", log_val[base + 1], 6);
      chk("t3_sum2", log_val[base + 2], 7);

      // T4: back-to-back commands, second waits for drain
      base = log_val.size();
      send_cmd(2, 0);
      send_op(3, 4, 0); send_op(5, 6, 0);
      send_cmd(1, 0);
      send_op(9, 9, 0);
      wait_idle();
      chk("t4_nsum", log_val.size() - base, 2);
      chk("t4_sum0", log_val[base], 42);
      chk("t4_sum1", log_val[base + 1], 81);
      chk("t4_order", accept_cyc > log_cyc[base], 1);

      // T5: abort mid-window, then abort racing a command in IDLE
      base = log_val.size();
      send_cmd(5, 0);
      send_op(8, 8, 0); send_op(8, 8, 0);
      pulse_abort();
      repeat (6) tick();
      chk("t5_nsum", log_val.size() - base, 0);
      chk("t5_busy", busy, 0);
      bus.cmd_valid = 1; pulse_abort(); bus.cmd_valid = 0;
      chk("t5_abort_wins", busy, 0);
      send_cmd(3, 0);
      send_op(1, 1, 0); send_op(1, 2, 1); send_op(1, 3, 0);
      wait_idle();
      chk("t5_sum", log_val[base], 6);

      // T6: zero-length window, then async reset mid-window
      base = log_val.size(); bbase = busy_cnt;
      send_cmd(0, 1);
      repeat (4) tick();
      chk("t6_busy_cycles", busy_cnt - bbase, 1);
      chk("t6_nsum", log_val.size() - base, 0);
      send_cmd(5, 0);
      send_op(2, 2, 0); send_op(3, 3, 0);
      #2 rst = 1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_cmd_ready", bus.cmd_ready, 1);
      chk("arst_op_ready", bus.op_ready, 0);
      chk("arst_mul_en", mul_en, 0);
      tick(); tick();
      rst = 0;
      tick();

      // randomized windows with bubbles, bypass and occasional aborts
      for (int w = 0; w < 40; w++) begin
         ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
         bp = ($urandom_range(0, 2) == 0);
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, ln)) : -1;
         send_cmd(ln, bp);
         for (int k = 0; k < ln; k++) begin
            if (k == ab) begin
               pulse_abort();
               break;
            end
            send_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3)));
         end
         if (ab == ln && ln > 0) pulse_abort();
         wait_idle();
         repeat ($urandom_range(0, 2)) tick();
      end

      // longest window the count width allows
      base = log_val.size();
      send_cmd(255, 0);
      for (int k = 0; k < 255; k++)
         send_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 ($urandom_range(0, 15) == 0) ? 1 : 0);
      wait_idle();
      chk("max_len_nsum", log_val.size() - base, 1);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
